mux_nto1_reg: RTL and testbench

//  Parametrised, registered N-to-1 multiplexer. It is the successor to the

---
 rtl/mux_nto1_reg_if.sv | 26 ++
 rtl/mux_nto1_reg.sv | 69 ++++++
 tb/tb_mux_nto1_reg.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_nto1_reg_if.sv
// Bus bundle for mux_nto1_reg: packed channel inputs, select/mode/hold controls and the
// registered outputs.
interface mux_nto1_reg_if #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] din;
    logic [SEL_W-1:0]        sel;
    logic                    mode;
    logic                    hold;
    logic [WIDTH-1:0]        dout;
    logic [SEL_W-1:0]        cur_sel;
    logic                    sel_changed;

    modport master (
        output din, sel, mode, hold,
        input  dout, cur_sel, sel_changed
    );

    modport slave (
        input  din, sel, mode, hold,
        output dout, cur_sel, sel_changed
    );
endinterface

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 multiplexer with manual select, an auto-scan sequencer that dwells
// DWELL cycles per channel, a hold/freeze control and a select-change pulse.
module mux_nto1_reg #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DWELL  = 4
) (
    input logic           clk,
    input logic           rst,
    mux_nto1_reg_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(NUM_CH);
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W + 1)'(NUM_CH);

    typedef enum logic {StManual, StScan} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SEL_W-1:0] cur_sel_q;
    logic [WIDTH-1:0] dout_q;
    logic             sel_changed_q;

    logic [CNT_W-1:0] cnt_cur;
    logic [CNT_W-1:0] cnt_d;
    logic [SEL_W-1:0] nsel;
    logic [WIDTH-1:0] din_sel;

    always_comb begin
        // Entering SCAN always begins a fresh dwell on the present channel
        cnt_cur = (state_q == StScan) ? cnt_q : '0;
        nsel    = cur_sel_q;
        cnt_d   = '0;
        if (bus.mode) begin
            if (cnt_cur == LAST_CNT) begin
                nsel = (cur_sel_q == LAST_CH) ? '0 : cur_sel_q + 1'b1;
            end else begin
                cnt_d = cnt_cur + 1'b1;
            end
        end else if ({1'b0, bus.sel} < NUM_CH_X) begin
            nsel = bus.sel;
        end
        din_sel = bus.din[int'(nsel) * int'(WIDTH) +: WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StManual;
            cnt_q         <= '0;
            cur_sel_q     <= '0;
            dout_q        <= '0;
            sel_changed_q <= 1'b0;
        end else if (bus.hold) begin
            sel_changed_q <= 1'b0;
        end else begin
            state_q       <= bus.mode ? StScan : StManual;
            cnt_q         <= cnt_d;
            cur_sel_q     <= nsel;
            dout_q        <= din_sel;
            sel_changed_q <= (nsel != cur_sel_q);
        end
    end

    assign bus.dout        = dout_q;
    assign bus.cur_sel     = cur_sel_q;
    assign bus.sel_changed = sel_changed_q;
endmodule

// File: tb/tb_mux_nto1_reg.sv
// Bench for mux_nto1_reg: three parameterisations checked against a channel-arithmetic
// reference model, plus a vector table and directed multi-cycle sequences.
module tb_mux_nto1_reg;
    localparam int unsigned WA = 2, NA = 4, DA = 4, DWA = 8;
    localparam int unsigned WB = 1, NB = 4, DB = 1, DWB = 4;
    localparam int unsigned WC = 3, NC = 3, DC = 2, DWC = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mux_nto1_reg_if #(.WIDTH(WA), .NUM_CH(NA)) ifa ();
    mux_nto1_reg_if #(.WIDTH(WB), .NUM_CH(NB)) ifb ();
    mux_nto1_reg_if #(.WIDTH(WC), .NUM_CH(NC)) ifc ();

    mux_nto1_reg #(.WIDTH(WA), .NUM_CH(NA), .DWELL(DA)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    mux_nto1_reg #(.WIDTH(WB), .NUM_CH(NB), .DWELL(DB)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    mux_nto1_reg #(.WIDTH(WC), .NUM_CH(NC), .DWELL(DC)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    // Scan position is derived from edges spent scanning: channel = start + k/dwell (mod n)
    typedef struct {
        int cur;
        int start;
        int k;
        bit scanning;
        int dout;
        bit changed;
    } mdl_t;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] din;
        logic       exp;
    } vec_t;

    mdl_t ma, mb, mc;
    vec_t vt[64];
    int   checks = 0;
    int   errors = 0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.cur = 0; m.start = 0; m.k = 0; m.scanning = 0; m.dout = 0; m.changed = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int nch, int dwell, int width,
                                      logic [63:0] din, int sel, bit mode, bit hold);
        int ns;
        if (hold) begin
            m.changed = 0;
            return m;
        end
        if (mode) begin
            if (!m.scanning) begin
                m.scanning = 1;
                m.start    = m.cur;
                m.k        = 0;
            end
            m.k = m.k + 1;
            ns  = (m.start + m.k / dwell) % nch;
        end else begin
            m.scanning = 0;
            ns = (sel < nch) ? sel : m.cur;
        end
        m.changed = (ns != m.cur);
        m.cur     = ns;
        m.dout    = int'((din >> (ns * width)) & ((64'd1 << width) - 64'd1));
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("a_dout", 64'(ifa.dout), 64'(ma.dout));
        check("a_cur_sel", 64'(ifa.cur_sel), 64'(ma.cur));
        check("a_sel_changed", 64'(ifa.sel_changed), 64'(ma.changed));
        check("b_dout", 64'(ifb.dout), 64'(mb.dout));
        check("b_cur_sel", 64'(ifb.cur_sel), 64'(mb.cur));
        check("b_sel_changed", 64'(ifb.sel_changed), 64'(mb.changed));
        check("c_dout", 64'(ifc.dout), 64'(mc.dout));
        check("c_cur_sel", 64'(ifc.cur_sel), 64'(mc.cur));
        check("c_sel_changed", 64'(ifc.sel_changed), 64'(mc.changed));
    endtask

    task automatic reset_models();
        ma = mdl_reset();
        mb = mdl_reset();
        mc = mdl_reset();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            reset_models();
        end else begin
            ma = mdl_step(ma, NA, DA, WA, 64'(ifa.din), int'(ifa.sel), ifa.mode, ifa.hold);
            mb = mdl_step(mb, NB, DB, WB, 64'(ifb.din), int'(ifb.sel), ifb.mode, ifb.hold);
            mc = mdl_step(mc, NC, DC, WC, 64'(ifc.din), int'(ifc.sel), ifc.mode, ifc.hold);
        end
        #1;
        check_all();
    endtask

    // Assert reset between edges and look at the outputs before any clock edge
    task automatic rst_now();
        rst = 1'b1;
        reset_models();
        #1;
        check_all();
    endtask

    initial begin
        int exp_b;
        ifa.din = '0; ifa.sel = '0; ifa.mode = 1'b0; ifa.hold = 1'b0;
        ifb.din = '0; ifb.sel = '0; ifb.mode = 1'b0; ifb.hold = 1'b0;
        ifc.din = '0; ifc.sel = '0; ifc.mode = 1'b0; ifc.hold = 1'b0;
        reset_models();

        #1;
        rst_now();
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 64; i++) begin
            vt[i].sel = 2'(i >> 4);
            vt[i].din = 4'(i);
            vt[i].exp = vt[i].din[vt[i].sel];
        end
        for (int i = 0; i < 64; i++) begin
            ifb.sel = vt[i].sel;
            ifb.din = vt[i].din;
            tick();
            check("sweep_dout", 64'(ifb.dout), 64'(vt[i].exp));
        end

        // DWELL=1: one channel per edge, starting from the last swept select (3)
        exp_b = 3;
        ifb.mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_b = (exp_b + 1) % 4;
            check("dwell1_cur_sel", 64'(ifb.cur_sel), 64'(exp_b));
            check("dwell1_changed", 64'(ifb.sel_changed), 64'd1);
        end
        ifb.mode = 1'b0;

        ifc.din = 9'b101_011_110;
        ifc.sel = 2'd2;
        tick();
        check("c_sel2_cur", 64'(ifc.cur_sel), 64'd2);
        check("c_sel2_dout", 64'(ifc.dout), 64'd5);
        ifc.sel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("oor_cur_sel", 64'(ifc.cur_sel), 64'd2);
            check("oor_dout", 64'(ifc.dout), 64'd5);
            check("oor_changed", 64'(ifc.sel_changed), 64'd0);
        end
        ifc.mode = 1'b1;
        tick();
        check("c_wrap_hold2", 64'(ifc.cur_sel), 64'd2);
        tick();
        check("c_wrap_to0", 64'(ifc.cur_sel), 64'd0);
        check("c_wrap_dout", 64'(ifc.dout), 64'd6);
        check("c_wrap_changed", 64'(ifc.sel_changed), 64'd1);
        ifc.mode = 1'b0;
        ifc.sel  = 2'd0;

        ifa.din  = 8'b11_10_01_00;
        ifa.mode = 1'b1;
        rst_now();
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            tick();
            check("scan_dout", 64'(ifa.dout), 64'((n / 4) % 4));
            check("scan_changed", 64'(ifa.sel_changed), 64'(n % 4 == 0));
        end

        // Frozen mid-dwell: two edges of channel 0's dwell remain
        ifa.hold = 1'b1;
        ifa.din  = 8'hff;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_dout", 64'(ifa.dout), 64'd0);
            check("hold_cur_sel", 64'(ifa.cur_sel), 64'd0);
            check("hold_changed", 64'(ifa.sel_changed), 64'd0);
        end
        ifa.hold = 1'b0;
        ifa.din  = 8'b11_10_01_00;
        tick();
        check("resume_cur_sel", 64'(ifa.cur_sel), 64'd0);
        tick();
        check("resume_adv", 64'(ifa.cur_sel), 64'd1);
        check("resume_changed", 64'(ifa.sel_changed), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check("scan_at2", 64'(ifa.cur_sel), 64'd2);

        ifa.mode = 1'b0;
        ifa.sel  = 2'd1;
        tick();
        check("to_manual_cur", 64'(ifa.cur_sel), 64'd1);
        check("to_manual_changed", 64'(ifa.sel_changed), 64'd1);
        ifa.mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rescan_ch1", 64'(ifa.cur_sel), 64'd1);
        end
        tick();
        check("rescan_ch2", 64'(ifa.cur_sel), 64'd2);
        check("rescan_dout", 64'(ifa.dout), 64'd2);

        rst_now();
        check("async_rst_dout", 64'(ifa.dout), 64'd0);
        check("async_rst_cur", 64'(ifa.cur_sel), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_cur", 64'(ifa.cur_sel), 64'd0);

        for (int i = 0; i < 400; i++) begin
            ifa.din = DWA'($urandom);
            ifb.din = DWB'($urandom);
            ifc.din = DWC'($urandom);
            ifa.sel = 2'($urandom);
            ifb.sel = 2'($urandom);
            ifc.sel = 2'($urandom);
            if ($urandom_range(15) == 0) ifa.mode = ~ifa.mode;
            if ($urandom_range(15) == 0) ifb.mode = ~ifb.mode;
            if ($urandom_range(15) == 0) ifc.mode = ~ifc.mode;
            ifa.hold = ($urandom_range(9) == 0);
            ifb.hold = ($urandom_range(9) == 0);
            ifc.hold = ($urandom_range(9) == 0);
            rst = ($urandom_range(63) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
